hdmi_pll_ctrl: RTL and testbench



---
 rtl/hdmi_pll_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hdmi_pll_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hdmi_pll_ctrl.sv
// hdmi_pll_ctrl
// Sequences the HDMI PLL: pulses pll_reset, waits for a synchronised lock,
// requires the lock to stay up for STABLE_CYCLES and then releases the
// pixel/serial-domain reset. A lock timeout retries with a stepped charge-pump
// current. After MAX_RETRIES further failures the block parks in FAIL. A lock
// loss in RUN re-sequences the PLL.
//
// Ports
//   clk, rst_n   50 MHz reference clock, async active-low reset
//   restart      one-cycle pulse, restarts the sequence from any state
//   pll_lock     raw PLL lock (asynchronous, synchronised here)
//   pll_reset    PLL reset, active high
//   icpsel       charge-pump current select
//   lpfres       loop-filter resistor select (static)
//   lpfcap       loop-filter capacitor select (static)
//   video_rst_n  registered active-low reset for pixel/TMDS logic
//   pll_ready    high in RUN only
//   pll_fail     high in FAIL only
//   retry_cnt    failed attempts in the current sequence
//   loss_cnt     lock-loss events since rst_n, saturating
module hdmi_pll_ctrl #(
    parameter int unsigned RST_CYCLES    = 64,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOSS_FILTER   = 4,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter logic [5:0]  ICP_INIT      = 6'd16,
    parameter logic [5:0]  ICP_STEP      = 6'd8,
    parameter logic [2:0]  LPFRES_INIT   = 3'd2,
    parameter logic [1:0]  LPFCAP_INIT   = 2'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] icpsel,
    output logic [2:0] lpfres,
    output logic [1:0] lpfcap,
    output logic       video_rst_n,
    output logic       pll_ready,
    output logic       pll_fail,
    output logic [1:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        RST_ASSERT,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic        lock_m;
    logic        lock_s;
    logic [6:0]  icp_sum;

    // One bit wider so the saturation at 63 can be seen.
    assign icp_sum = {1'b0, icpsel} + {1'b0, ICP_STEP};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RST_ASSERT;
            cnt         <= '0;
            lock_m      <= 1'b0;
            lock_s      <= 1'b0;
            pll_reset   <= 1'b1;
            icpsel      <= ICP_INIT;
            lpfres      <= LPFRES_INIT;
            lpfcap      <= LPFCAP_INIT;
            video_rst_n <= 1'b0;
            pll_ready   <= 1'b0;
            pll_fail    <= 1'b0;
            retry_cnt   <= '0;
            loss_cnt    <= '0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
            if (restart) begin
                state       <= RST_ASSERT;
                cnt         <= '0;
                pll_reset   <= 1'b1;
                icpsel      <= ICP_INIT;
                video_rst_n <= 1'b0;
                pll_ready   <= 1'b0;
                pll_fail    <= 1'b0;
                retry_cnt   <= '0;
            end else begin
                case (state)
                    RST_ASSERT: begin
                        if (cnt == 32'(RST_CYCLES - 1)) begin
                            state     <= WAIT_LOCK;
                            cnt       <= '0;
                            pll_reset <= 1'b0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else if (cnt == 32'(LOCK_TIMEOUT - 1)) begin
                            cnt       <= '0;
                            pll_reset <= 1'b1;
                            if (retry_cnt == 2'(MAX_RETRIES)) begin
                                state    <= FAIL;
                                pll_fail <= 1'b1;
                            end else begin
                                state     <= RST_ASSERT;
                                retry_cnt <= retry_cnt + 2'd1;
                                icpsel    <= (icp_sum > 7'd63) ? 6'd63 : icp_sum[5:0];
                            end
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    STABLE: begin
                        // The WAIT_LOCK cycle that saw lock_s high is the first
                        // of the STABLE_CYCLES consecutive high samples.
                        if (!lock_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == 32'(STABLE_CYCLES - 2)) begin
                            state       <= RUN;
                            cnt         <= '0;
                            video_rst_n <= 1'b1;
                            pll_ready   <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    RUN: begin
                        // cnt counts consecutive low lock samples here.
                        if (lock_s) begin
                            cnt <= '0;
                        end else if (cnt == 32'(LOSS_FILTER - 1)) begin
                            state       <= RST_ASSERT;
                            cnt         <= '0;
                            pll_reset   <= 1'b1;
                            video_rst_n <= 1'b0;
                            pll_ready   <= 1'b0;
                            retry_cnt   <= '0;
                            if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    FAIL: begin
                        // Parked until restart or rst_n.
                        pll_reset <= 1'b1;
                        pll_fail  <= 1'b1;
                    end
                    default: begin
                        state <= RST_ASSERT;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdmi_pll_ctrl.sv
// Directed bench for hdmi_pll_ctrl with small timing parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_hdmi_pll_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       restart;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] icpsel;
    logic [2:0] lpfres;
    logic [1:0] lpfcap;
    logic       video_rst_n;
    logic       pll_ready;
    logic       pll_fail;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hdmi_pll_ctrl #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .LOSS_FILTER(2),
        .MAX_RETRIES(2), .ICP_INIT(6'd16), .ICP_STEP(6'd8),
        .LPFRES_INIT(3'd2), .LPFCAP_INIT(2'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .pll_lock(pll_lock),
        .pll_reset(pll_reset), .icpsel(icpsel), .lpfres(lpfres), .lpfcap(lpfcap),
        .video_rst_n(video_rst_n), .pll_ready(pll_ready), .pll_fail(pll_fail),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    // One table row: drive inputs, advance n edges, compare outputs.
    typedef struct {
        string      name;
        logic       rs;
        logic       lk;
        int         n;
        logic       pr;
        logic [5:0] icp;
        logic       vid;
        logic       rdy;
        logic       fl;
        logic [1:0] rc;
        logic [7:0] lc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input logic rs, input logic lk, input int n,
                       input logic pr, input logic [5:0] icp, input logic vid,
                       input logic rdy, input logic fl, input logic [1:0] rc,
                       input logic [7:0] lc);
        vec_t v;
        v.name = name; v.rs = rs; v.lk = lk; v.n = n; v.pr = pr; v.icp = icp;
        v.vid = vid; v.rdy = rdy; v.fl = fl; v.rc = rc; v.lc = lc;
        tbl.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {12'd0, pll_reset, icpsel, video_rst_n, pll_ready, pll_fail, retry_cnt, loss_cnt};
    endfunction

    function automatic logic [31:0] pack(input logic pr, input logic [5:0] icp, input logic vid,
                                         input logic rdy, input logic fl, input logic [1:0] rc,
                                         input logic [7:0] lc);
        return {12'd0, pr, icp, vid, rdy, fl, rc, lc};
    endfunction

    initial begin
        // Nominal bring-up: lock arrives while in WAIT_LOCK.
        add("nom_rst_hold",   0, 0,   3, 1, 16, 0, 0, 0, 0, 0);
        add("nom_rst_fall",   0, 0,   1, 0, 16, 0, 0, 0, 0, 0);
        add("nom_wait",       0, 0,   2, 0, 16, 0, 0, 0, 0, 0);
        add("nom_pre_rel",    0, 1,   9, 0, 16, 0, 0, 0, 0, 0);
        add("nom_release",    0, 1,   1, 0, 16, 1, 1, 0, 0, 0);
        // One-cycle glitch is filtered out.
        add("gl1_low",        0, 0,   1, 0, 16, 1, 1, 0, 0, 0);
        add("gl1_ride",       0, 1,   4, 0, 16, 1, 1, 0, 0, 0);
        add("gl1_settle",     0, 1,   3, 0, 16, 1, 1, 0, 0, 0);
        // Three-cycle drop is a lock loss.
        add("gl3_a",          0, 0,   2, 0, 16, 1, 1, 0, 0, 0);
        add("gl3_b",          0, 0,   1, 0, 16, 1, 1, 0, 0, 0);
        add("gl3_loss",       0, 1,   1, 1, 16, 0, 0, 0, 0, 1);
        add("gl3_rst",        0, 1,   3, 1, 16, 0, 0, 0, 0, 1);
        add("gl3_rst_fall",   0, 1,   1, 0, 16, 0, 0, 0, 0, 1);
        add("gl3_pre",        0, 1,   7, 0, 16, 0, 0, 0, 0, 1);
        add("gl3_relock",     0, 1,   1, 0, 16, 1, 1, 0, 0, 1);
        // Retry sweep with lock held low, started by a restart from RUN.
        add("rs_restart",     1, 0,   1, 1, 16, 0, 0, 0, 0, 1);
        add("rs_a0_hold",     0, 0,   3, 1, 16, 0, 0, 0, 0, 1);
        add("rs_a0_fall",     0, 0,   1, 0, 16, 0, 0, 0, 0, 1);
        add("rs_a0_wait",     0, 0,  19, 0, 16, 0, 0, 0, 0, 1);
        add("rs_retry1",      0, 0,   1, 1, 24, 0, 0, 0, 1, 1);
        add("rs_a1_hold",     0, 0,   3, 1, 24, 0, 0, 0, 1, 1);
        add("rs_a1_fall",     0, 0,   1, 0, 24, 0, 0, 0, 1, 1);
        add("rs_a1_wait",     0, 0,  19, 0, 24, 0, 0, 0, 1, 1);
        add("rs_retry2",      0, 0,   1, 1, 32, 0, 0, 0, 2, 1);
        add("rs_a2_hold",     0, 0,   3, 1, 32, 0, 0, 0, 2, 1);
        add("rs_a2_fall",     0, 0,   1, 0, 32, 0, 0, 0, 2, 1);
        add("rs_a2_wait",     0, 0,  19, 0, 32, 0, 0, 0, 2, 1);
        add("rs_fail",        0, 0,   1, 1, 32, 0, 0, 1, 2, 1);
        add("rs_fail_hold",   0, 0, 200, 1, 32, 0, 0, 1, 2, 1);
        // Restart out of FAIL with lock present.
        add("rf_restart",     1, 1,   1, 1, 16, 0, 0, 0, 0, 1);
        add("rf_hold",        0, 1,   3, 1, 16, 0, 0, 0, 0, 1);
        add("rf_fall",        0, 1,   1, 0, 16, 0, 0, 0, 0, 1);
        add("rf_pre",         0, 1,   7, 0, 16, 0, 0, 0, 0, 1);
        add("rf_run",         0, 1,   1, 0, 16, 1, 1, 0, 0, 1);
        // Lock bounces during STABLE; count must restart.
        add("bo_restart",     1, 0,   1, 1, 16, 0, 0, 0, 0, 1);
        add("bo_fall",        0, 0,   4, 0, 16, 0, 0, 0, 0, 1);
        add("bo_hi5",         0, 1,   5, 0, 16, 0, 0, 0, 0, 1);
        add("bo_lo2",         0, 0,   2, 0, 16, 0, 0, 0, 0, 1);
        add("bo_pre",         0, 1,   9, 0, 16, 0, 0, 0, 0, 1);
        add("bo_run",         0, 1,   1, 0, 16, 1, 1, 0, 0, 1);

        rst_n = 1'b1; restart = 1'b0; pll_lock = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_outs", outs(), pack(1, 16, 0, 0, 0, 0, 0));
        chk("reset_lpf", {27'd0, lpfres, lpfcap}, {27'd0, 3'd2, 2'd0});
        step(3);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            restart  = tbl[i].rs;
            pll_lock = tbl[i].lk;
            step(tbl[i].n);
            chk(tbl[i].name, outs(),
                pack(tbl[i].pr, tbl[i].icp, tbl[i].vid, tbl[i].rdy, tbl[i].fl,
                     tbl[i].rc, tbl[i].lc));
        end

        // Asynchronous reset in the middle of STABLE.
        restart = 1'b1; pll_lock = 1'b1;
        step(1);
        restart = 1'b0;
        step(7);
        chk("ar_in_stable", outs(), pack(0, 16, 0, 0, 0, 0, 1));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_async_outs", outs(), pack(1, 16, 0, 0, 0, 0, 0));
        chk("ar_async_lpf", {27'd0, lpfres, lpfcap}, {27'd0, 3'd2, 2'd0});
        step(2);
        chk("ar_held", outs(), pack(1, 16, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        step(4);
        chk("ar_rst_fall", outs(), pack(0, 16, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
